// File: rtl/uart_rx_fifo.sv
// ============================================================================
// Module   : uart_rx_fifo
// Summary  : 8N1 UART receiver with a 16-entry first-word-fall-through FIFO.
// Revision : 1.0
// ============================================================================
`default_nettype none

module uart_rx_fifo #(
   parameter int CLKS_PER_BIT = 25,
   parameter int DEPTH_LOG2   = 4
) (
   input  logic                  clk,
   input  logic                  nreset,
   input  logic                  rx,
   input  logic                  rd,
   input  logic                  clr_ovf,
   output logic [7:0]            q,
   output logic [DEPTH_LOG2:0]   count,
   output logic                  empty,
   output logic                  overflow,
   output logic                  rx_int,
   output logic                  frame_err
);

   localparam int TW    = $clog2(CLKS_PER_BIT);
   localparam int DEPTH = 1 << DEPTH_LOG2;
   localparam logic [TW-1:0]         HALF_RELOAD = TW'(CLKS_PER_BIT / 2 - 1);
   localparam logic [TW-1:0]         BIT_RELOAD  = TW'(CLKS_PER_BIT - 1);
   localparam logic [DEPTH_LOG2:0]   FULL_COUNT  = (DEPTH_LOG2 + 1)'(DEPTH);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_START = 3'd1;
   localparam logic [2:0] S_DATA  = 3'd2;
   localparam logic [2:0] S_STOP  = 3'd3;
   localparam logic [2:0] S_BREAK = 3'd4;

   logic [2:0]            state, state_next;
   logic                  sync1, rxs, rxs_d;
   logic [TW-1:0]         tmr;
   logic [2:0]            idx;
   logic [7:0]            shreg;
   logic                  fall, tick, push, ferr;

   logic [7:0]            mem [DEPTH];
   logic [DEPTH_LOG2-1:0] wp, rp, rp_next;
   logic                  full, do_push, do_pop;

   // Synchroniser plus one extra stage for falling-edge detection
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         sync1 <= 1'b1;
         rxs   <= 1'b1;
         rxs_d <= 1'b1;
      end else begin
         sync1 <= rx;
         rxs   <= sync1;
         rxs_d <= rxs;
      end
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) state <= S_IDLE;
      else         state <= state_next;
   end

   always_comb begin
      state_next = state;
      case (state)
         S_IDLE:  if (fall) state_next = S_START;
         S_START: if (tick) state_next = rxs ? S_IDLE : S_DATA;
         S_DATA:  if (tick && idx == 3'd7) state_next = S_STOP;
         S_STOP:  if (tick) state_next = rxs ? S_IDLE : S_BREAK;
         S_BREAK: if (rxs) state_next = S_IDLE;
         default: state_next = S_IDLE;
      endcase
   end

   always_comb begin
      fall = rxs_d & ~rxs;
      tick = (tmr == '0);
      push = (state == S_STOP) && tick && rxs;
      ferr = (state == S_STOP) && tick && !rxs;
   end

   // Bit timer, bit index and LSB-first shift register
   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         tmr   <= '0;
         idx   <= '0;
         shreg <= '0;
      end else if (state == S_IDLE) begin
         if (fall) tmr <= HALF_RELOAD;
      end else if (!tick) begin
         tmr <= tmr - 1'b1;
      end else begin
         tmr <= BIT_RELOAD;
         if (state == S_START) idx <= '0;
         if (state == S_DATA) begin
            shreg <= {rxs, shreg[7:1]};
            idx   <= idx + 1'b1;
         end
      end
   end

   always_comb begin
      empty   = (count == '0);
      full    = (count == FULL_COUNT);
      do_pop  = rd && !empty;
      do_push = push && (!full || rd);
      rp_next = rp + 1'b1;
   end

   always_ff @(posedge clk) begin
      if (do_push) mem[wp] <= shreg;
   end

   always_ff @(posedge clk or negedge nreset) begin
      if (!nreset) begin
         wp        <= '0;
         rp        <= '0;
         count     <= '0;
         q         <= '0;
         overflow  <= 1'b0;
         rx_int    <= 1'b0;
         frame_err <= 1'b0;
      end else begin
         rx_int    <= do_push;
         frame_err <= ferr;
         if (do_push) wp <= wp + 1'b1;
         if (do_pop)  rp <= rp_next;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
         // Head register: next entry on pop, incoming byte if it becomes the head
         if (do_pop) begin
            if (count > (DEPTH_LOG2 + 1)'(1)) q <= mem[rp_next];
            else if (do_push)                 q <= shreg;
         end else if (do_push && empty) begin
            q <= shreg;
         end
         if (push && full && !rd) overflow <= 1'b1;
         else if (clr_ovf)        overflow <= 1'b0;
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
// ============================================================================
// Module   : tb_uart_rx_fifo
// Summary  : Directed self-checking bench for uart_rx_fifo.
// Revision : 1.0
// ============================================================================
`default_nettype none

module tb_uart_rx_fifo;

   logic       clk = 1'b0;
   logic       nreset = 1'b0;
   logic       rx = 1'b1;
   logic       rd = 1'b0;
   logic       clr_ovf = 1'b0;
   logic [7:0] q;
   logic [4:0] count;
   logic       empty, overflow, rx_int, frame_err;

   int checks = 0;
   int errors = 0;
   int int_cnt = 0;
   int ferr_cnt = 0;

   uart_rx_fifo #(.CLKS_PER_BIT(25), .DEPTH_LOG2(4)) dut (
      .clk(clk), .nreset(nreset), .rx(rx), .rd(rd), .clr_ovf(clr_ovf),
      .q(q), .count(count), .empty(empty), .overflow(overflow),
      .rx_int(rx_int), .frame_err(frame_err)
   );

   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (rx_int)    int_cnt++;
      if (frame_err) ferr_cnt++;
   end

   initial begin
      #20ms;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One 250-cycle frame; rd or reset can be pulsed at a chosen cycle
   task automatic send(input logic [7:0] d, input logic stop, input int rd_cyc, input int rst_cyc);
      for (int c = 0; c < 250; c++) begin
         if (c < 25)       rx = 1'b0;
         else if (c < 225) rx = d[(c - 25) / 25];
         else              rx = stop;
         rd     = (c == rd_cyc);
         nreset = (c != rst_cyc);
         tick(1);
      end
      rd = 1'b0;
      nreset = 1'b1;
   endtask

   task automatic pop();
      rd = 1'b1;
      tick(1);
      rd = 1'b0;
   endtask

   task automatic test_reset();
      nreset = 1'b0;
      tick(3);
      checks++;
      if ({q, count, empty, overflow, rx_int, frame_err} !== {8'h00, 5'd0, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL reset_outputs: got q=%h count=%0d empty=%b ovf=%b int=%b ferr=%b expected 00/0/1/0/0/0",
                  q, count, empty, overflow, rx_int, frame_err);
      end
      nreset = 1'b1;
      tick(5);
   endtask

   task automatic test_single_byte();
      int n0;
      n0 = int_cnt;
      send(8'hA5, 1'b1, -1, -1);
      tick(5);
      checks++;
      if (int_cnt - n0 !== 1) begin errors++; $display("FAIL single_int: got %0d pulses expected 1", int_cnt - n0); end
      checks++;
      if (q !== 8'hA5) begin errors++; $display("FAIL single_q: got %h expected a5", q); end
      checks++;
      if (count !== 5'd1 || empty !== 1'b0) begin errors++; $display("FAIL single_count: got %0d/%b expected 1/0", count, empty); end
      pop();
      checks++;
      if (count !== 5'd0 || empty !== 1'b1) begin errors++; $display("FAIL single_pop: got %0d/%b expected 0/1", count, empty); end
      pop();
      checks++;
      if (count !== 5'd0 || empty !== 1'b1 || q !== 8'hA5) begin
         errors++; $display("FAIL empty_rd: got count=%0d empty=%b q=%h expected 0/1/a5", count, empty, q);
      end
   endtask

   task automatic test_burst();
      int n0;
      n0 = int_cnt;
      for (int i = 0; i < 17; i++) send(8'(i), 1'b1, -1, -1);
      tick(5);
      checks++;
      if (int_cnt - n0 !== 16) begin errors++; $display("FAIL burst_int: got %0d pulses expected 16", int_cnt - n0); end
      checks++;
      if (count !== 5'd16 || overflow !== 1'b1 || q !== 8'h00) begin
         errors++; $display("FAIL burst_full: got count=%0d ovf=%b q=%h expected 16/1/00", count, overflow, q);
      end
      for (int i = 0; i < 16; i++) begin
         checks++;
         if (q !== 8'(i)) begin errors++; $display("FAIL burst_order: got %h expected %h", q, 8'(i)); end
         pop();
      end
      checks++;
      if (empty !== 1'b1 || overflow !== 1'b1) begin errors++; $display("FAIL burst_drain: got empty=%b ovf=%b expected 1/1", empty, overflow); end
      clr_ovf = 1'b1;
      tick(1);
      clr_ovf = 1'b0;
      checks++;
      if (overflow !== 1'b0) begin errors++; $display("FAIL clr_ovf: got %b expected 0", overflow); end
   endtask

   task automatic test_full_with_read();
      int n0;
      for (int i = 0; i < 16; i++) send(8'h20 + 8'(i), 1'b1, -1, -1);
      checks++;
      if (count !== 5'd16) begin errors++; $display("FAIL fullrd_fill: got %0d expected 16", count); end
      n0 = int_cnt;
      send(8'h55, 1'b1, 239, -1);
      tick(5);
      checks++;
      if (count !== 5'd16 || overflow !== 1'b0 || int_cnt - n0 !== 1) begin
         errors++; $display("FAIL fullrd_push: got count=%0d ovf=%b ints=%0d expected 16/0/1", count, overflow, int_cnt - n0);
      end
      for (int i = 1; i < 16; i++) begin
         checks++;
         if (q !== 8'h20 + 8'(i)) begin errors++; $display("FAIL fullrd_order: got %h expected %h", q, 8'h20 + 8'(i)); end
         pop();
      end
      checks++;
      if (q !== 8'h55) begin errors++; $display("FAIL fullrd_last: got %h expected 55", q); end
      pop();
      checks++;
      if (empty !== 1'b1) begin errors++; $display("FAIL fullrd_empty: got %b expected 1", empty); end
   endtask

   task automatic test_frame_err();
      int n0, f0;
      send(8'h07, 1'b1, -1, -1);
      n0 = int_cnt;
      f0 = ferr_cnt;
      send(8'h3C, 1'b0, -1, -1);
      tick(40);
      rx = 1'b1;
      tick(30);
      checks++;
      if (ferr_cnt - f0 !== 1 || int_cnt - n0 !== 0 || count !== 5'd1) begin
         errors++; $display("FAIL frame_err: got ferr=%0d ints=%0d count=%0d expected 1/0/1", ferr_cnt - f0, int_cnt - n0, count);
      end
      send(8'h81, 1'b1, -1, -1);
      tick(5);
      checks++;
      if (count !== 5'd2 || q !== 8'h07) begin errors++; $display("FAIL ferr_next_cnt: got %0d/%h expected 2/07", count, q); end
      pop();
      checks++;
      if (q !== 8'h81) begin errors++; $display("FAIL ferr_next_q: got %h expected 81", q); end
      pop();
   endtask

   task automatic test_glitch();
      int n0, f0;
      n0 = int_cnt;
      f0 = ferr_cnt;
      rx = 1'b0;
      tick(8);
      rx = 1'b1;
      tick(40);
      checks++;
      if (int_cnt - n0 !== 0 || ferr_cnt - f0 !== 0 || dut.state !== 3'd0 || count !== 5'd0) begin
         errors++; $display("FAIL glitch: got ints=%0d ferr=%0d state=%0d count=%0d expected 0/0/0/0",
                            int_cnt - n0, ferr_cnt - f0, dut.state, count);
      end
   endtask

   task automatic test_reset_mid_frame();
      send(8'h01, 1'b1, -1, -1);
      send(8'h02, 1'b1, -1, -1);
      send(8'h03, 1'b1, -1, -1);
      checks++;
      if (count !== 5'd3 || q !== 8'h01) begin errors++; $display("FAIL rst_fill: got %0d/%h expected 3/01", count, q); end
      send(8'hFF, 1'b1, -1, 135);
      tick(5);
      checks++;
      if ({q, count, empty, overflow, rx_int, frame_err} !== {8'h00, 5'd0, 1'b1, 3'b000}) begin
         errors++;
         $display("FAIL rst_mid_frame: got q=%h count=%0d empty=%b ovf=%b int=%b ferr=%b expected 00/0/1/0/0/0",
                  q, count, empty, overflow, rx_int, frame_err);
      end
      send(8'h12, 1'b1, -1, -1);
      tick(5);
      checks++;
      if (count !== 5'd1 || q !== 8'h12) begin errors++; $display("FAIL rst_after: got %0d/%h expected 1/12", count, q); end
      pop();
   endtask

   initial begin
      test_reset();
      test_single_byte();
      test_burst();
      test_full_with_read();
      test_frame_err();
      test_glitch();
      test_reset_mid_frame();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

`default_nettype wire
